calc_req_arbiter: RTL and testbench
===================================

CALC_REQ_ARBITER -- requirements
Module: calc_req_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 64, meaning the maximum number of cycles to wait for alu_done before aborting.
REQ-002 SHALL have port c_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_cmd_in, input, 16 bits: 4-bit command per requester; port 1 is in the most-significant nibble.
REQ-005 SHALL have port req_data_in, input, 128 bits: 32-bit operand per requester; port 1 is in the most-significant word.
REQ-006 SHALL have port out_resp, output, 8 bits: 2-bit response per port; 00 none, 01 success, 10 invalid/overflow, 11 timeout.
REQ-007 SHALL have port out_data, output, 128 bits: 32-bit result per port, valid only while that port's out_resp is 01.
REQ-008 SHALL have port port_busy, output, 4 bits: slot of port n is occupied.
REQ-009 SHALL have port alu_valid, output, 1 bit: one-cycle issue strobe to the shared ALU.
REQ-010 SHALL have ports alu_cmd (output, 4 bits), alu_op1 (output, 32 bits) and alu_op2 (output, 32 bits): the issued command and operands.
REQ-011 SHALL have port alu_done, input, 1 bit: ALU completion strobe.
REQ-012 SHALL have ports alu_resp (input, 2 bits) and alu_data (input, 32 bits): the ALU result, sampled when alu_done is 1.

Function
REQ-013 SHALL hold one slot per port with states EMPTY, OP2, PEND and BUSY.
REQ-014 SHALL, in EMPTY with a nonzero cmd, capture cmd and data as op1 and go to OP2.
REQ-015 SHALL, in OP2, capture data as op2 on the next cycle and go to PEND, regardless of that cycle's cmd.
REQ-016 SHALL treat commands 1 (add), 2 (sub), 5 (shl) and 6 (shr) as valid.
REQ-017 SHALL, for any other nonzero cmd, drive out_resp=10 and out_data=0 for that port in the cycle after op2 capture, then return the slot to EMPTY without an ALU issue.
REQ-018 SHALL ignore a nonzero cmd on a port whose slot is not EMPTY; no response and no state change result.
REQ-019 SHALL sequence the ALU with a main FSM of states IDLE, ISSUE, WAIT and RESP.
REQ-020 SHALL, in IDLE with at least one PEND slot, grant one slot, mark it BUSY and go to ISSUE.
REQ-021 SHALL, in ISSUE, drive alu_valid=1 for exactly one cycle with the granted cmd and operands, then go to WAIT.
REQ-022 SHALL hold alu_cmd, alu_op1 and alu_op2 stable from ISSUE until the FSM leaves WAIT.
REQ-023 SHALL, in WAIT, latch alu_resp and alu_data and go to RESP when alu_done=1.
REQ-024 SHALL, in WAIT after TIMEOUT_CYC cycles without alu_done, latch resp=11 and data=0 and go to RESP.
REQ-025 SHALL ignore alu_done in any state other than WAIT.
REQ-026 SHALL, in RESP, drive the granted port's out_resp and out_data for exactly one cycle, set its slot to EMPTY and go to IDLE.
REQ-027 SHALL produce a granted response in the second cycle after alu_done.
REQ-028 SHALL hold each port's out_resp at 00 and its out_data at 0 in every cycle it does not respond.
REQ-029 SHALL allow an invalid-command response and an ALU response to appear in the same cycle on different ports.
REQ-030 SHALL allow a slot freed in RESP to capture a new cmd in the following cycle.
REQ-031 SHALL take port_busy[n]=1 whenever the slot of port n is not EMPTY.

Reset
REQ-032 SHALL, while reset=1, set all slots to EMPTY, the FSM to IDLE, the round-robin pointer to port 1 and the timeout counter to 0.
REQ-033 SHALL, while reset=1, drive out_resp, out_data, port_busy, alu_valid, alu_cmd, alu_op1 and alu_op2 to 0.
REQ-034 SHALL, on reset mid-operation, drop all in-flight requests with no response and ignore any later alu_done from them.

Configuration
REQ-035 SHALL, with ARB_ROUND_ROBIN_EN defined, grant the first PEND port after the last-granted port in cyclic order 1-2-3-4, with the pointer advancing on each grant.
REQ-036 SHALL, without ARB_ROUND_ROBIN_EN, use fixed priority with port 1 highest and port 4 lowest, and have no pointer state.

Verification
REQ-037 SHALL cover: port 1 issues cmd 1 with op1=5, op2=7; ALU returns done with resp=01, data=12 -> alu_cmd=1, alu_op1=5, alu_op2=7; port 1 sees out_resp=01, out_data=12 for one cycle.
REQ-038 SHALL cover: port 3 issues cmd 9 with op1=1, op2=2 -> no alu_valid; port 3 sees out_resp=10 in the cycle after op2.
REQ-039 SHALL cover: all four ports issue cmd 2 in the same cycle with ARB_ROUND_ROBIN_EN defined -> grants in order 1, 2, 3, 4; without the macro, a port 1 request re-issued in each gap is always granted first.
REQ-040 SHALL cover: ALU never asserts alu_done -> after 64 WAIT cycles the granted port sees out_resp=11, out_data=0, and the FSM returns to IDLE.
REQ-041 SHALL cover: reset asserted during WAIT, then alu_done arrives after reset release -> no out_resp, all port_busy=0, alu_valid=0.
REQ-042 SHALL cover: a new cmd on a BUSY port -> ignored; only the original request receives a response.

Source files
------------

// File: rtl/calc_req_arbiter.sv
// calc_req_arbiter: four request slots sharing one ALU, with an ALU timeout. Port 1 is the top lane of every bus.
// ARB_ROUND_ROBIN_EN selects round-robin grants; without it, fixed priority with port 1 highest.
module calc_req_arbiter #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic         c_clk,
    input  logic         reset,
    input  logic [15:0]  req_cmd_in,
    input  logic [127:0] req_data_in,
    output logic [7:0]   out_resp,
    output logic [127:0] out_data,
    output logic [3:0]   port_busy,
    output logic         alu_valid,
    output logic [3:0]   alu_cmd,
    output logic [31:0]  alu_op1,
    output logic [31:0]  alu_op2,
    input  logic         alu_done,
    input  logic [1:0]   alu_resp,
    input  logic [31:0]  alu_data
);
    localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    typedef enum logic [1:0] {EMPTY, OP2, PEND, BUSY} slot_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} fsm_t;
    slot_t slot_q [4];
    slot_t slot_d [4];
    logic [3:0] cmd_q [4];
    logic [3:0] cmd_d [4];
    logic [31:0] op1_q [4];
    logic [31:0] op1_d [4];
    logic [31:0] op2_q [4];
    logic [31:0] op2_d [4];
    fsm_t st_q, st_d;
    logic [1:0] gnt_q, gnt_d, sel, idx;
    logic found;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0] rsp_q, rsp_d;
    logic [31:0] dat_q, dat_d;
    logic [7:0] resp_d;
    logic [127:0] odata_d;
    logic [3:0] acmd_d;
    logic [31:0] aop1_d, aop2_d;
`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;
`endif

    function automatic logic ok_cmd(input logic [3:0] c);
        return c inside {4'd1, 4'd2, 4'd5, 4'd6};
    endfunction

    assign alu_valid = st_q == ISSUE;

    // internal slot index 0 is port 1; the search start is the pointer in round-robin mode
    always_comb begin
        found = 1'b0;
        sel = '0;
        idx = '0;
        for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
            idx = ptr_q + 2'(i);
`else
            idx = 2'(i);
`endif
            if (!found && slot_q[idx] == PEND) begin
                found = 1'b1;
                sel = idx;
            end
            port_busy[3-i] = slot_q[i] != EMPTY;
        end
    end

    always_comb begin
        slot_d = slot_q;
        cmd_d = cmd_q;
        op1_d = op1_q;
        op2_d = op2_q;
        st_d = st_q;
        gnt_d = gnt_q;
        cnt_d = cnt_q;
        rsp_d = rsp_q;
        dat_d = dat_q;
        acmd_d = alu_cmd;
        aop1_d = alu_op1;
        aop2_d = alu_op2;
        resp_d = '0;
        odata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d = ptr_q;
`endif
        for (int i = 0; i < 4; i++) begin
            if (slot_q[i] == EMPTY && req_cmd_in[(3-i)*4 +: 4] != 4'd0) begin
                slot_d[i] = OP2;
                cmd_d[i] = req_cmd_in[(3-i)*4 +: 4];
                op1_d[i] = req_data_in[(3-i)*32 +: 32];
            end else if (slot_q[i] == OP2) begin
                op2_d[i] = req_data_in[(3-i)*32 +: 32];
                slot_d[i] = ok_cmd(cmd_q[i]) ? PEND : EMPTY;
                resp_d[(3-i)*2 +: 2] = ok_cmd(cmd_q[i]) ? 2'b00 : 2'b10;
            end
        end
        case (st_q)
            IDLE: if (found) begin
                slot_d[sel] = BUSY;
                gnt_d = sel;
                acmd_d = cmd_q[sel];
                aop1_d = op1_q[sel];
                aop2_d = op2_q[sel];
                st_d = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                ptr_d = sel + 2'd1;
`endif
            end
            ISSUE: begin
                cnt_d = '0;
                st_d = WAIT;
            end
            WAIT: if (alu_done) begin
                rsp_d = alu_resp;
                dat_d = alu_data;
                st_d = RESP;
            end else if (cnt_q == CW'(TIMEOUT_CYC - 1)) begin
                rsp_d = 2'b11;
                dat_d = '0;
                st_d = RESP;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: begin
                resp_d[{~gnt_q, 1'b0} +: 2] = rsp_q;
                odata_d[{~gnt_q, 5'd0} +: 32] = rsp_q == 2'b01 ? dat_q : 32'd0;
                slot_d[gnt_q] = EMPTY;
                st_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge c_clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= EMPTY;
                cmd_q[i] <= '0;
                op1_q[i] <= '0;
                op2_q[i] <= '0;
            end
            st_q <= IDLE;
            gnt_q <= '0;
            cnt_q <= '0;
            rsp_q <= '0;
            dat_q <= '0;
            out_resp <= '0;
            out_data <= '0;
            alu_cmd <= '0;
            alu_op1 <= '0;
            alu_op2 <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q <= '0;
`endif
        end else begin
            slot_q <= slot_d;
            cmd_q <= cmd_d;
            op1_q <= op1_d;
            op2_q <= op2_d;
            st_q <= st_d;
            gnt_q <= gnt_d;
            cnt_q <= cnt_d;
            rsp_q <= rsp_d;
            dat_q <= dat_d;
            out_resp <= resp_d;
            out_data <= odata_d;
            alu_cmd <= acmd_d;
            alu_op1 <= aop1_d;
            alu_op2 <= aop2_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q <= ptr_d;
`endif
        end
    end
endmodule

// File: tb/tb_calc_req_arbiter.sv
// tb_calc_req_arbiter: vector table, directed corner sequences and a timeline-based random model for calc_req_arbiter.
module tb_calc_req_arbiter;
    logic c_clk = 1'b0;
    logic reset = 1'b1;
    logic [15:0] req_cmd_in = '0;
    logic [127:0] req_data_in = '0;
    logic [7:0] out_resp;
    logic [127:0] out_data;
    logic [3:0] port_busy;
    logic alu_valid;
    logic [3:0] alu_cmd;
    logic [31:0] alu_op1, alu_op2;
    logic alu_done = 1'b0;
    logic [1:0] alu_resp = '0;
    logic [31:0] alu_data = '0;
    int checks = 0, passed = 0, cyc = 0;

    calc_req_arbiter #(.TIMEOUT_CYC(64)) dut (
        .c_clk(c_clk), .reset(reset), .req_cmd_in(req_cmd_in), .req_data_in(req_data_in),
        .out_resp(out_resp), .out_data(out_data), .port_busy(port_busy), .alu_valid(alu_valid),
        .alu_cmd(alu_cmd), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_done(alu_done),
        .alu_resp(alu_resp), .alu_data(alu_data)
    );

    always #5 c_clk = ~c_clk;

    typedef struct {
        logic [15:0] cmd;
        logic [127:0] data;
        logic done;
        logic [31:0] adata;
        logic [7:0] eresp;
        logic [127:0] edata;
        logic [3:0] ebusy;
        logic evalid;
        logic chk_alu;
        logic [3:0] ecmd;
        logic [31:0] eop1;
        logic [31:0] eop2;
    } vec_t;
    vec_t tv [9];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge c_clk);
        #1;
        cyc++;
    endtask

    task automatic samp();
        @(negedge c_clk);
    endtask

    task automatic idle_in();
        req_cmd_in = '0;
        req_data_in = '0;
        alu_done = 1'b0;
        alu_resp = '0;
        alu_data = '0;
    endtask

    task automatic set_port(input int p, input logic [3:0] c, input logic [31:0] d);
        req_cmd_in[(4-p)*4 +: 4] = c;
        req_data_in[(4-p)*32 +: 32] = d;
    endtask

    function automatic logic [1:0] resp_of(input int p);
        return out_resp[(4-p)*2 +: 2];
    endfunction

    function automatic logic [31:0] data_of(input int p);
        return out_data[(4-p)*32 +: 32];
    endfunction

    function automatic logic [127:0] pk(input logic [31:0] a, b, c, d);
        return {a, b, c, d};
    endfunction

    function automatic logic [31:0] alu_f(input logic [3:0] c, input logic [31:0] a, b);
        case (c)
            4'd1: return a + b;
            4'd2: return a - b;
            4'd5: return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    task automatic req(input int p, input logic [3:0] c, input logic [31:0] a, b);
        step(); idle_in(); set_port(p, c, a); samp();
        step(); idle_in(); set_port(p, 4'd0, b); samp();
    endtask

    int ph [5], gap [5], ecy [5];
    logic [3:0] rc [5];
    logic [31:0] r1 [5], r2 [5], ed [5];
    logic [1:0] er [5];
    bit isf [5];
    logic [3:0] vc [4] = '{4'd1, 4'd2, 4'd5, 4'd6};

    initial begin
        int iss, got, reiss, re_at, nv, nr, bad, ap, acnt, quiet, m;
        int order [$];
        int exp_order [6];
        logic [3:0] scmd, v;
        logic [31:0] s1, s2;
        logic e;
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 2, 3, 4, 1, 1};
`else
        exp_order = '{1, 2, 1, 3, 1, 4};
`endif
        tv[0] = '{16'h1090, pk(5, 0, 1, 0), 1'b0, 32'd0, 8'h00, 128'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0};
        tv[1] = '{16'h0000, pk(7, 0, 2, 0), 1'b0, 32'd0, 8'h00, 128'd0, 4'b1010, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0};
        tv[2] = '{16'h0000, 128'd0, 1'b1, 32'd99, 8'h08, 128'd0, 4'b1000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0};
        tv[3] = '{16'h0000, 128'd0, 1'b0, 32'd0, 8'h00, 128'd0, 4'b1000, 1'b1, 1'b1, 4'd1, 32'd5, 32'd7};
        tv[4] = '{16'h0000, 128'd0, 1'b1, 32'd12, 8'h00, 128'd0, 4'b1000, 1'b0, 1'b1, 4'd1, 32'd5, 32'd7};
        tv[5] = '{16'h0000, 128'd0, 1'b0, 32'd0, 8'h00, 128'd0, 4'b1000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0};
        tv[6] = '{16'h0000, 128'd0, 1'b0, 32'd0, 8'h40, pk(12, 0, 0, 0), 4'b0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0};
        tv[7] = '{16'h0000, 128'd0, 1'b1, 32'd55, 8'h00, 128'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0};
        tv[8] = '{16'h0000, 128'd0, 1'b0, 32'd0, 8'h00, 128'd0, 4'b0000, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0};

        repeat (2) @(posedge c_clk);
        samp();
        chk("reset out_resp", out_resp, 0);
        chk("reset out_data", out_data, 0);
        chk("reset busy", port_busy, 0);
        chk("reset alu", {alu_valid, alu_cmd, alu_op1, alu_op2}, 0);

        for (int i = 0; i < 9; i++) begin
            step();
            reset = 1'b0;
            req_cmd_in = tv[i].cmd;
            req_data_in = tv[i].data;
            alu_done = tv[i].done;
            alu_resp = 2'b01;
            alu_data = tv[i].adata;
            samp();
            chk($sformatf("v%0d out_resp", i), out_resp, tv[i].eresp);
            chk($sformatf("v%0d out_data", i), out_data, tv[i].edata);
            chk($sformatf("v%0d port_busy", i), port_busy, tv[i].ebusy);
            chk($sformatf("v%0d alu_valid", i), alu_valid, tv[i].evalid);
            if (tv[i].chk_alu) chk($sformatf("v%0d alu bus", i), {alu_cmd, alu_op1, alu_op2}, {tv[i].ecmd, tv[i].eop1, tv[i].eop2});
        end

        // all four ports at once; port 1 re-requests right after each of its first two responses
        step(); idle_in(); for (int p = 1; p <= 4; p++) set_port(p, 4'd2, 32'(p)); samp();
        step(); idle_in(); samp();
        iss = -10; reiss = 0; re_at = -1;
        for (int k = 0; k < 300; k++) begin
            step();
            idle_in();
            if (cyc == re_at) set_port(1, 4'd2, 32'd1);
            alu_done = cyc == iss + 2;
            alu_resp = 2'b01;
            samp();
            if (alu_valid) begin
                order.push_back(int'(alu_op1));
                iss = cyc;
            end
            if (resp_of(1) != 2'b00 && reiss < 2) begin
                reiss++;
                re_at = cyc + 1;
            end
            if (order.size() == 6 && cyc > iss + 5) break;
        end
        chk("grant count", order.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("grant %0d", i), (i < order.size()) ? order[i] : -1, exp_order[i]);

        // ALU never answers
        req(2, 4'd1, 32'hA, 32'hB);
        iss = -1; got = -1;
        for (int k = 0; k < 150 && got < 0; k++) begin
            step(); idle_in(); samp();
            if (alu_valid && iss < 0) iss = cyc;
            if (resp_of(2) != 2'b00) begin
                got = cyc;
                chk("timeout resp", resp_of(2), 2'b11);
                chk("timeout data", data_of(2), 0);
            end
        end
        chk("timeout latency", got - iss, 66);
        req(4, 4'd1, 32'd3, 32'd4);
        iss = -1; nr = 0;
        for (int k = 0; k < 15; k++) begin
            step(); idle_in();
            alu_done = iss >= 0 && cyc == iss + 1;
            alu_resp = 2'b01;
            alu_data = 32'd7;
            samp();
            if (alu_valid && iss < 0) iss = cyc;
            if (resp_of(4) != 2'b00) nr++;
        end
        chk("after timeout issue", iss >= 0, 1);
        chk("after timeout resp", nr, 1);

        // reset in WAIT, stale alu_done afterwards
        req(1, 4'd1, 32'd5, 32'd6);
        iss = -1;
        for (int k = 0; k < 10 && iss < 0; k++) begin
            step(); idle_in(); samp();
            if (alu_valid) iss = cyc;
        end
        step(); idle_in(); reset = 1'b1; samp();
        chk("midreset busy", port_busy, 0);
        chk("midreset alu", {alu_valid, alu_cmd, alu_op1, alu_op2}, 0);
        chk("midreset resp", out_resp, 0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            step(); idle_in(); reset = 1'b0;
            alu_done = 1'b1; alu_resp = 2'b01; alu_data = 32'd11;
            samp();
            if (out_resp != 0 || port_busy != 0 || alu_valid) bad++;
        end
        chk("post-reset quiet cycles", bad, 0);

        // new cmd on a BUSY port
        req(2, 4'd1, 32'd3, 32'd4);
        iss = -1; nv = 0; nr = 0;
        for (int k = 0; k < 25; k++) begin
            step(); idle_in();
            if (iss >= 0 && (cyc == iss + 1 || cyc == iss + 2)) set_port(2, 4'd2, 32'd99);
            alu_done = iss >= 0 && cyc == iss + 3;
            alu_resp = 2'b01;
            alu_data = 32'd7;
            samp();
            if (alu_valid) begin
                nv++;
                if (iss < 0) iss = cyc;
            end
            if (resp_of(2) != 2'b00) begin
                nr++;
                chk("busy-ignore data", {resp_of(2), data_of(2)}, {2'b01, 32'd7});
            end
        end
        chk("busy-ignore issues", nv, 1);
        chk("busy-ignore responses", nr, 1);

        // random traffic against a per-port response timeline
        for (int p = 1; p <= 4; p++) begin
            ph[p] = 0;
            gap[p] = $urandom_range(0, 3);
            isf[p] = 0;
        end
        ap = 0; acnt = 0; quiet = -1; scmd = 0; s1 = 0; s2 = 0;
        for (int k = 0; k < 3000; k++) begin
            step();
            req_cmd_in = '0;
            req_data_in = {$urandom, $urandom, $urandom, $urandom};
            alu_done = 1'b0;
            alu_resp = 2'($urandom);
            alu_data = $urandom;
            for (int p = 1; p <= 4; p++) begin
                if (ph[p] == 0) begin
                    if (gap[p] == 0) begin
                        v = 4'($urandom_range(3, 15));
                        if (v == 4'd5 || v == 4'd6) v = 4'd7;
                        rc[p] = ($urandom_range(0, 4) == 0) ? v : vc[$urandom_range(0, 3)];
                        r1[p] = $urandom;
                        r2[p] = $urandom;
                        set_port(p, rc[p], r1[p]);
                        ph[p] = 1;
                    end else gap[p]--;
                end else if (ph[p] == 1) begin
                    set_port(p, 4'($urandom), r2[p]);
                    if (rc[p] inside {4'd1, 4'd2, 4'd5, 4'd6}) ph[p] = 2;
                    else begin
                        ph[p] = 3; ecy[p] = cyc + 1; er[p] = 2'b10; ed[p] = 0;
                    end
                end
            end
            if (ap != 0) begin
                if (acnt == 0) begin
                    alu_done = 1'b1;
                    alu_resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b01;
                    alu_data = (alu_resp == 2'b01) ? alu_f(rc[ap], r1[ap], r2[ap]) : $urandom;
                    er[ap] = alu_resp;
                    ed[ap] = (alu_resp == 2'b01) ? alu_data : 32'd0;
                    ecy[ap] = cyc + 2;
                    ph[ap] = 3;
                    ap = 0;
                end else acnt--;
            end else if (cyc > quiet && $urandom_range(0, 7) == 0) alu_done = 1'b1;
            samp();
            if (alu_valid) begin
                m = 0;
                for (int p = 1; p <= 4; p++)
                    if (ph[p] == 2 && !isf[p] && alu_cmd == rc[p] && alu_op1 == r1[p] && alu_op2 == r2[p]) m = p;
                chk("rand issue matches a pending request", m != 0, 1);
                chk("rand issue while ALU idle", ap == 0 && cyc > quiet, 1);
                if (m != 0) begin
                    isf[m] = 1;
                    if ($urandom_range(0, 39) == 0) begin
                        ph[m] = 3; ecy[m] = cyc + 66; er[m] = 2'b11; ed[m] = 0; quiet = cyc + 65;
                    end else begin
                        ap = m; acnt = $urandom_range(0, 6); scmd = alu_cmd; s1 = alu_op1; s2 = alu_op2;
                    end
                end
            end else if (ap != 0) chk("rand alu bus stable", {alu_cmd, alu_op1, alu_op2}, {scmd, s1, s2});
            for (int p = 1; p <= 4; p++) begin
                e = ph[p] == 3 && ecy[p] == cyc;
                chk($sformatf("rand p%0d resp c%0d", p, cyc), resp_of(p), e ? er[p] : 2'b00);
                chk($sformatf("rand p%0d data c%0d", p, cyc), data_of(p), e ? ed[p] : 32'd0);
                chk($sformatf("rand p%0d busy c%0d", p, cyc), port_busy[4-p], ph[p] == 2 || (ph[p] == 3 && cyc < ecy[p]));
                if (e) begin
                    ph[p] = 0; isf[p] = 0; gap[p] = $urandom_range(0, 3);
                end
            end
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
